// File: rtl/vp_attr_delay_pkg.sv
// Shared constants for the attribute delay line.
// Combinational only; no state, no flow control.
package vp_attr_delay_pkg;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
endpackage

// File: rtl/vp_shift_line.sv
// Stallable shift register exposing every stage as a tap; bit 0 of each word is its valid flag.
// One advance per stage; holds when advance is low, clear_valid wins over a shift.
module vp_shift_line
  import vp_attr_delay_pkg::*;
#(
  parameter int WIDTH     = 49,
  parameter int MAX_DELAY = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            advance,
  input  logic                            clear_valid,
  input  logic [WIDTH-1:0]                din,
  output logic [MAX_DELAY-1:0][WIDTH-1:0] taps
);

  always_ff @(posedge clk) begin
    if (reset) begin
      taps <= '0;
    end else if (clear_valid) begin
      // Data bits are kept; only the qualifiers are dropped.
      for (int i = 0; i < MAX_DELAY; i++) begin
        taps[i][0] <= FALSE;
      end
    end else if (advance) begin
      taps[0] <= din;
      for (int i = 1; i < MAX_DELAY; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

endmodule

// File: rtl/vp_attr_delay.sv
// Run-time selectable delay line realigning attribute words with the pixel stream.
// Latency Deff advance cycles; stalls (holds everything) while advance is low.
module vp_attr_delay
  import vp_attr_delay_pkg::*;
#(
  parameter int WIDTH      = 48,
  parameter int MAX_DELAY  = 8,
  parameter int DELAY_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  flush,
  input  logic [DELAY_BITS-1:0] delay,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  cfg_err
);

  localparam logic [DELAY_BITS-1:0] MAX_D = DELAY_BITS'(MAX_DELAY);

  logic [MAX_DELAY-1:0][WIDTH:0] taps;
  logic [WIDTH:0]                sel;
  logic [DELAY_BITS-1:0]         deff;
  logic [DELAY_BITS-1:0]         d_q;
  logic [DELAY_BITS-1:0]         fill;
  logic                          delay_bad;
  logic                          changed;
  logic                          fill_ok;

  vp_shift_line #(
    .WIDTH     (WIDTH + 1),
    .MAX_DELAY (MAX_DELAY)
  ) u_line (
    .clk         (clk),
    .reset       (reset),
    .advance     (advance),
    .clear_valid (flush),
    .din         ({in_data, in_valid}),
    .taps        (taps)
  );

  always_comb begin
    delay_bad = (delay == '0) || (delay > MAX_D);
    if (delay == '0) begin
      deff = DELAY_BITS'(1);
    end else if (delay > MAX_D) begin
      deff = MAX_D;
    end else begin
      deff = delay;
    end
  end

  // Deff==1 bypasses storage; Deff==k reads stage k-2, which already holds k-1 advances of age.
  always_comb begin
    sel = {in_data, in_valid};
    for (int i = 0; i < MAX_DELAY - 1; i++) begin
      if (deff == DELAY_BITS'(i + 2)) begin
        sel = taps[i];
      end
    end
  end

  assign changed = (d_q != deff);
  assign fill_ok = ({1'b0, fill} + (DELAY_BITS + 1)'(1)) >= {1'b0, deff};

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= FALSE;
      cfg_err   <= FALSE;
      fill      <= '0;
      d_q       <= '0;
    end else begin
      cfg_err <= delay_bad;
      d_q     <= deff;
      if (flush) begin
        out_valid <= FALSE;
        fill      <= '0;
      end else begin
        if (advance) begin
          out_data  <= sel[WIDTH:1];
          out_valid <= sel[0] && fill_ok && !changed;
        end else if (changed) begin
          out_valid <= FALSE;
        end
        // Stages may still hold words from the old setting; refill before trusting them.
        if (changed) begin
          fill <= '0;
        end else if (advance && fill != MAX_D) begin
          fill <= fill + DELAY_BITS'(1);
        end
      end
    end
  end

endmodule
